fetch_queue: RTL and testbench

- Instruction fetch front end with a prefetch queue. Sits directly upstream of the fetch/decode pipeline buffer and replaces the bare PC/increment/instruction-memory path.
- Holds the fetch PC and issues word requests to a variable-latency instruction memory with a req/ack handshake.
- Buffers returned instructions in a small FIFO, each paired with its PC+4, and presents them to decode under a stall signal.
- Memory-stage branch redirects flush the queue and restart fetch.

---
 rtl/fetch_queue.sv | 156 +++++++++++++++
 tb/tb_fetch_queue.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: holds the fetch PC, issues word requests to instruction memory, and buffers {instr, pc+4} pairs for decode.
// Optional: define FETCH_BYPASS_EN so an ack that arrives while the FIFO is empty reaches decode in the same cycle.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  output logic                   imemReq_o,
  output logic [31:0]            imemAddr_o,
  input  logic                   imemAck_i,
  input  logic [31:0]            imemData_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirectAddr_i,
  input  logic                   stall_i,
  output logic                   valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            nextInstrAddr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  state_t        stateNext;
  logic [31:0]   pc;
  logic [31:0]   pcNext;
  logic [31:0]   pcPlus4;
  logic [31:0]   reqAddr;
  logic          reqActive;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic [AW:0]   countNext;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   nextMem  [DEPTH];
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifoEmpty;
  logic          bypassHit;
  logic          bypassTake;

  assign pcPlus4   = pc + 32'd4;
  assign fifoEmpty = (count == '0);
  // Only a live (non-discarded) request can deliver data; redirect wins over it.
  assign accept    = (state == REQ) && imemAck_i && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign bypassHit  = accept && fifoEmpty;
  assign bypassTake = bypassHit && !stall_i;
`else
  assign bypassHit  = 1'b0;
  assign bypassTake = 1'b0;
`endif

  assign push = accept && !bypassTake;
  assign pop  = !fifoEmpty && !stall_i && !redirect_i;

  always_comb begin
    countNext = count;
    if (redirect_i) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + ONE;
    end else if (pop && !push) begin
      countNext = count - ONE;
    end
  end

  always_comb begin
    pcNext = pc;
    if (redirect_i) begin
      pcNext = {redirectAddr_i[31:2], 2'b00};
    end else if (accept) begin
      pcNext = pcPlus4;
    end
  end

  // Entering or staying in REQ is decided on next-cycle occupancy, so an
  // outstanding request always has a free slot waiting for it.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = (countNext < FULL) ? REQ : IDLE;
      REQ: begin
        if (imemAck_i) begin
          stateNext = (countNext < FULL) ? REQ : IDLE;
        end else if (redirect_i) begin
          stateNext = DROP;
        end else begin
          stateNext = REQ;
        end
      end
      DROP: stateNext = imemAck_i ? IDLE : DROP;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      reqAddr   <= RESET_PC;
      reqActive <= 1'b0;
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      reqActive <= (stateNext != IDLE);
      // DROP keeps presenting the abandoned address until its ack arrives.
      if (stateNext == REQ) begin
        reqAddr <= pcNext;
      end
      count <= countNext;
      if (redirect_i) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      instrMem[wrPtr] <= imemData_i;
      nextMem[wrPtr]  <= pcPlus4;
    end
  end

  assign imemReq_o  = reqActive;
  assign imemAddr_o = reqAddr;
  assign count_o    = count;

  always_comb begin
    valid_o         = !fifoEmpty || bypassHit;
    instr_o         = '0;
    nextInstrAddr_o = '0;
    if (!fifoEmpty) begin
      instr_o         = instrMem[rdPtr];
      nextInstrAddr_o = nextMem[rdPtr];
    end else if (bypassHit) begin
      instr_o         = imemData_i;
      nextInstrAddr_o = pcPlus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory model returns the address as data, scoreboard checks decode order.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          imemReq;
  logic [31:0]   imemAddr;
  logic          imemAck      = 1'b0;
  logic [31:0]   imemData     = 32'h0;
  logic          redirect     = 1'b0;
  logic [31:0]   redirectAddr = 32'h0;
  logic          stall        = 1'b0;
  logic          valid;
  logic [31:0]   instr;
  logic [31:0]   nextAddr;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] nxt;
  } exp_t;

  exp_t expQ[$];
  exp_t sbE;
  int   checks   = 0;
  int   failures = 0;
  int   memLat   = 0;
  int   waitCnt  = 0;
  int   ackCount = 0;
  int   popCount = 0;
  bit   lateAck  = 1'b0;
  bit   sbEn     = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .imemReq_o      (imemReq),
    .imemAddr_o     (imemAddr),
    .imemAck_i      (imemAck),
    .imemData_i     (imemData),
    .redirect_i     (redirect),
    .redirectAddr_i (redirectAddr),
    .stall_i        (stall),
    .valid_o        (valid),
    .instr_o        (instr),
    .nextInstrAddr_o(nextAddr),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  // Memory: acks on the (memLat+1)-th cycle of a request, data = address.
  always @(negedge clk) begin
    if (lateAck) begin
      imemAck  = 1'b1;
      imemData = 32'hDEAD_BEEF;
    end else if (rst_n && imemReq) begin
      if (waitCnt >= memLat) begin
        imemAck  = 1'b1;
        imemData = imemAddr;
        waitCnt  = 0;
        ackCount = ackCount + 1;
      end else begin
        imemAck = 1'b0;
        waitCnt = waitCnt + 1;
      end
    end else begin
      imemAck = 1'b0;
      waitCnt = 0;
    end
  end

  // Scoreboard: every instruction consumed by decode must be the next expected one.
  always @(negedge clk) begin
    #1;
    if (sbEn && rst_n && valid && !stall && !redirect) begin
      checks = checks + 1;
      if (expQ.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb_extra: got instr=%h next=%h, required no output", instr, nextAddr);
      end else begin
        sbE      = expQ.pop_front();
        popCount = popCount + 1;
        if (instr !== sbE.instr || nextAddr !== sbE.nxt) begin
          failures = failures + 1;
          $display("FAIL sb_order: got instr=%h next=%h, required instr=%h next=%h",
                   instr, nextAddr, sbE.instr, sbE.nxt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic fillExp(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.instr = start + 32'(4 * i);
      e.nxt   = start + 32'(4 * i + 4);
      expQ.push_back(e);
    end
  endtask

  task automatic doReset(input logic st, input int lat);
    sbEn     = 1'b0;
    redirect = 1'b0;
    lateAck  = 1'b0;
    stall    = st;
    memLat   = lat;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQ.delete();
    ackCount = 0;
  endtask

  task automatic test_reset();
    doReset(1'b0, 0);
    sample();
    checks = checks + 1;
    if (imemReq !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_req: got %b, required 0", imemReq);
    end
    checks = checks + 1;
    if (valid !== 1'b0 || count !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_valid_count: got valid=%b count=%0d, required 0/0", valid, count);
    end
    checks = checks + 1;
    if (instr !== 32'h0 || nextAddr !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got instr=%h next=%h, required 0/0", instr, nextAddr);
    end
  endtask

  task automatic test_stream();
    int p0;
    doReset(1'b0, 0);
    fillExp(32'h0, 64);
    sbEn = 1'b1;
    p0   = popCount;
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      checks = checks + 1;
      if (imemReq !== 1'b1 || imemAddr !== 32'(4 * k)) begin
        failures = failures + 1;
        $display("FAIL stream_req%0d: got req=%b addr=%h, required 1/%h", k, imemReq, imemAddr, 32'(4 * k));
      end
`ifndef FETCH_BYPASS_EN
      checks = checks + 1;
      if (k == 0 && valid !== 1'b0) begin
        failures = failures + 1;
        $display("FAIL stream_latency: got valid=%b in first ack cycle, required 0", valid);
      end else if (k > 0 && (valid !== 1'b1 || nextAddr !== 32'(4 * k))) begin
        failures = failures + 1;
        $display("FAIL stream_valid%0d: got valid=%b next=%h, required 1/%h", k, valid, nextAddr, 32'(4 * k));
      end
`endif
    end
    repeat (20) tick();
    checks = checks + 1;
    if (popCount - p0 < 20) begin
      failures = failures + 1;
      $display("FAIL stream_throughput: got %0d pops, required >= 20", popCount - p0);
    end
  endtask

  task automatic test_stall_full();
    int p0;
    doReset(1'b1, 0);
    fillExp(32'h0, 64);
    sbEn = 1'b1;
    repeat (10) tick();
    sample();
    checks = checks + 1;
    if (ackCount !== 4 || count !== CW'(DEPTH)) begin
      failures = failures + 1;
      $display("FAIL full_count: got acks=%0d count=%0d, required 4/4", ackCount, count);
    end
    checks = checks + 1;
    if (imemReq !== 1'b0 || valid !== 1'b1 || instr !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL full_state: got req=%b valid=%b instr=%h, required 0/1/0", imemReq, valid, instr);
    end
    tick();
    stall = 1'b0;
    p0    = popCount;
    repeat (20) tick();
    checks = checks + 1;
    if (popCount - p0 !== 20) begin
      failures = failures + 1;
      $display("FAIL drain_rate: got %0d pops in 20 cycles, required 20", popCount - p0);
    end
    checks = checks + 1;
    if (imemReq !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL drain_resume: got req=%b, required 1", imemReq);
    end
  endtask

  task automatic test_latency();
    int          vq[$];
    logic        pReq  = 1'b0;
    logic        pAck  = 1'b0;
    logic [31:0] pAddr = 32'h0;
    doReset(1'b0, 3);
    fillExp(32'h0, 32);
    sbEn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      sample();
      if (imemReq && pReq && !pAck) begin
        checks = checks + 1;
        if (imemAddr !== pAddr) begin
          failures = failures + 1;
          $display("FAIL lat_addr_stable: got %h, required %h", imemAddr, pAddr);
        end
      end
      pReq  = imemReq;
      pAck  = imemAck;
      pAddr = imemAddr;
      if (valid) vq.push_back(i);
    end
    checks = checks + 1;
    if (vq.size() < 5) begin
      failures = failures + 1;
      $display("FAIL lat_pulses: got %0d valid cycles, required >= 5", vq.size());
    end else begin
      for (int j = 1; j < 5; j++) begin
        checks = checks + 1;
        if (vq[j] - vq[j-1] != 4) begin
          failures = failures + 1;
          $display("FAIL lat_gap%0d: got %0d, required 4", j, vq[j] - vq[j-1]);
        end
      end
    end
  endtask

  task automatic test_redirect_pending();
    bit found = 1'b0;
    doReset(1'b0, 3);
    fillExp(32'h0, 4);
    sbEn = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      sample();
      if (imemReq && imemAddr == 32'h10 && !imemAck) found = 1'b1;
    end
    checks = checks + 1;
    if (!found) begin
      failures = failures + 1;
      $display("FAIL redir_setup: got no request at 00000010, required one");
      return;
    end
    tick();
    redirect     = 1'b1;
    redirectAddr = 32'h0000_0103;
    expQ.delete();
    fillExp(32'h100, 32);
    tick();
    redirect = 1'b0;
    sample();
    checks = checks + 1;
    if (count !== '0 || valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL redir_flush: got count=%0d valid=%b, required 0/0", count, valid);
    end
    checks = checks + 1;
    if (imemReq !== 1'b1 || imemAddr !== 32'h10) begin
      failures = failures + 1;
      $display("FAIL redir_hold: got req=%b addr=%h, required 1/00000010", imemReq, imemAddr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      sample();
      if (imemReq && imemAddr !== 32'h10) found = 1'b1;
    end
    checks = checks + 1;
    if (!found || imemAddr !== 32'h100) begin
      failures = failures + 1;
      $display("FAIL redir_target: got found=%b addr=%h, required 1/00000100", found, imemAddr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      sample();
      if (valid) found = 1'b1;
    end
    checks = checks + 1;
    if (!found || instr !== 32'h100 || nextAddr !== 32'h104) begin
      failures = failures + 1;
      $display("FAIL redir_first: got valid=%b instr=%h next=%h, required 1/00000100/00000104",
               found, instr, nextAddr);
    end
  endtask

  task automatic test_redirect_ack();
    bit found = 1'b0;
    int p0;
    doReset(1'b1, 0);
    sbEn = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (count == CW'(2) && imemReq) found = 1'b1;
    end
    checks = checks + 1;
    if (!found) begin
      failures = failures + 1;
      $display("FAIL redack_setup: got no cycle with count=2, required one");
      return;
    end
    redirect     = 1'b1;
    redirectAddr = 32'h0000_0200;
    stall        = 1'b0;
    expQ.delete();
    fillExp(32'h200, 32);
    sample();
    checks = checks + 1;
    if (imemAck !== 1'b1 || valid !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL redack_coincide: got ack=%b valid=%b, required 1/1", imemAck, valid);
    end
    tick();
    redirect = 1'b0;
    sample();
    checks = checks + 1;
    if (count !== '0) begin
      failures = failures + 1;
      $display("FAIL redack_count: got %0d, required 0", count);
    end
`ifndef FETCH_BYPASS_EN
    checks = checks + 1;
    if (valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL redack_valid: got %b, required 0", valid);
    end
`endif
    checks = checks + 1;
    if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin
      failures = failures + 1;
      $display("FAIL redack_target: got req=%b addr=%h, required 1/00000200", imemReq, imemAddr);
    end
    p0 = popCount;
    repeat (10) tick();
    checks = checks + 1;
    if (popCount - p0 < 5) begin
      failures = failures + 1;
      $display("FAIL redack_resume: got %0d pops, required >= 5", popCount - p0);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int p0;
    doReset(1'b1, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (count == CW'(3) && imemReq) found = 1'b1;
    end
    checks = checks + 1;
    if (!found) begin
      failures = failures + 1;
      $display("FAIL rstmid_setup: got no cycle with count=3, required one");
      return;
    end
    rst_n = 1'b0;
    sample();
    tick();
    rst_n   = 1'b1;
    stall   = 1'b0;
    lateAck = 1'b1;
    sample();
    checks = checks + 1;
    if (count !== '0 || valid !== 1'b0 || imemReq !== 1'b0 || instr !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL rstmid_clear: got count=%0d valid=%b req=%b instr=%h, required 0/0/0/0",
               count, valid, imemReq, instr);
    end
    tick();
    lateAck = 1'b0;
    expQ.delete();
    fillExp(32'h0, 32);
    sbEn = 1'b1;
    sample();
    checks = checks + 1;
    if (count !== '0 || imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL rstmid_restart: got count=%0d req=%b addr=%h, required 0/1/00000000",
               count, imemReq, imemAddr);
    end
    p0 = popCount;
    repeat (10) tick();
    checks = checks + 1;
    if (popCount - p0 < 5) begin
      failures = failures + 1;
      $display("FAIL rstmid_resume: got %0d pops, required >= 5", popCount - p0);
    end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    bit found = 1'b0;
    doReset(1'b0, 3);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      sample();
      if (imemAck && count == '0) found = 1'b1;
    end
    checks = checks + 1;
    if (!found || valid !== 1'b1 || instr !== imemAddr || nextAddr !== imemAddr + 32'd4) begin
      failures = failures + 1;
      $display("FAIL bypass_same_cycle: got valid=%b instr=%h next=%h, required 1/%h/%h",
               valid, instr, nextAddr, imemAddr, imemAddr + 32'd4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall_full();
    test_latency();
    test_redirect_pending();
    test_redirect_ack();
    test_reset_mid();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
